// File: rtl/maverickOne_pkg.sv
// Shared definitions for the maverickOne register-lock tracking logic.
//   NUM_REGS        : number of architectural registers (register 0 is hardwired zero)
//   NUM_OUTSTANDING : maximum number of launched instructions that may be in flight
//   blk_state_e     : state of the blocking-instruction tracker
package maverickOne_pkg;

    localparam int NUM_REGS        = 32;
    localparam int NUM_OUTSTANDING = 4;

    typedef enum logic {
        BLK_IDLE    = 1'b0,
        BLK_BLOCKED = 1'b1
    } blk_state_e;

endpackage

// File: rtl/reg_lock_cnt.sv
// Single per-register in-flight counter.
//   clk_i     : system clock
//   arst_ni   : asynchronous active-low reset
//   clear_i   : synchronous flush, overrides inc_i/dec_i
//   inc_i     : one more write to this register is in flight
//   dec_i     : one in-flight write to this register completed
//   nonzero_o : registered flag, count != 0
// The count saturates at both ends; inc and dec together leave it unchanged.
module reg_lock_cnt #(
    parameter int MAX_COUNT = maverickOne_pkg::NUM_OUTSTANDING,
    localparam int W = $clog2(MAX_COUNT + 1)
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic clear_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         nonzero_q;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && (cnt_q != W'(MAX_COUNT))) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q     <= '0;
            nonzero_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            nonzero_q <= (cnt_d != '0);
        end
    end

    assign nonzero_o = nonzero_q;

endmodule

// File: rtl/reg_lock_tracker.sv
// Tracks which destination registers have writes in flight and produces the
// lock vector the launcher uses to stall dependent instructions.
//   clk_i             : system clock
//   arst_ni           : asynchronous active-low reset
//   clear_i           : synchronous flush of all tracking (err_o is kept)
//   launch_valid_i    : an instruction is launched this cycle
//   launch_rd_i       : destination register of the launched instruction
//   launch_blocking_i : the launched instruction is blocking
//   wb_valid_i        : one write-back completes this cycle
//   wb_rd_i           : register completed by the write-back
//   blk_done_i        : the pending blocking instruction has retired
//   locks_o           : per-register lock vector
//   outstanding_o     : number of instructions in flight
//   full_o            : outstanding_o == NUM_OUTSTANDING
//   err_o             : sticky protocol-error flag, cleared only by reset
module reg_lock_tracker #(
    parameter int NUM_REGS        = maverickOne_pkg::NUM_REGS,
    parameter int NUM_OUTSTANDING = maverickOne_pkg::NUM_OUTSTANDING,
    localparam int RW = $clog2(NUM_REGS),
    localparam int OW = $clog2(NUM_OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                clear_i,
    input  logic                launch_valid_i,
    input  logic [RW-1:0]       launch_rd_i,
    input  logic                launch_blocking_i,
    input  logic                wb_valid_i,
    input  logic [RW-1:0]       wb_rd_i,
    input  logic                blk_done_i,
    output logic [NUM_REGS-1:0] locks_o,
    output logic [OW-1:0]       outstanding_o,
    output logic                full_o,
    output logic                err_o
);

    maverickOne_pkg::blk_state_e state_q;

    logic [OW-1:0]       outstanding_q;
    logic [OW-1:0]       outstanding_d;
    logic                full_q;
    logic                err_q;
    logic [NUM_REGS-1:0] nonzero;
    logic                wb_hit;
    logic                wb_acc;
    logic                launch_acc;
    logic                err_set;

    // Register 0 has no counter. A write-back to r0 is only checked against
    // the global count, since r0 launches are still real in-flight work.
    always_comb begin
        wb_hit        = 1'b0;
        wb_acc        = 1'b0;
        launch_acc    = 1'b0;
        err_set       = 1'b0;
        outstanding_d = outstanding_q;

        if (wb_rd_i == '0) begin
            wb_hit = (outstanding_q != '0);
        end else begin
            wb_hit = nonzero[wb_rd_i];
        end
        wb_acc = wb_valid_i && wb_hit;

        // A same-cycle accepted write-back frees a slot, so a launch while
        // full is legal in that cycle.
        launch_acc = launch_valid_i
                  && (state_q == maverickOne_pkg::BLK_IDLE)
                  && (!full_q || wb_acc);

        err_set = (launch_valid_i && !launch_acc)
               || (wb_valid_i && !wb_acc)
               || (blk_done_i && (state_q == maverickOne_pkg::BLK_IDLE));

        if (launch_acc && !wb_acc) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (wb_acc && !launch_acc) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    assign nonzero[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        reg_lock_cnt #(
            .MAX_COUNT (NUM_OUTSTANDING)
        ) u_cnt (
            .clk_i     (clk_i),
            .arst_ni   (arst_ni),
            .clear_i   (clear_i),
            .inc_i     (launch_acc && (launch_rd_i == RW'(r))),
            .dec_i     (wb_acc && (wb_rd_i == RW'(r))),
            .nonzero_o (nonzero[r])
        );
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q       <= maverickOne_pkg::BLK_IDLE;
            outstanding_q <= '0;
            full_q        <= 1'b0;
            err_q         <= 1'b0;
        end else if (clear_i) begin
            state_q       <= maverickOne_pkg::BLK_IDLE;
            outstanding_q <= '0;
            full_q        <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            full_q        <= (outstanding_d == OW'(NUM_OUTSTANDING));
            if (err_set) begin
                err_q <= 1'b1;
            end
            case (state_q)
                maverickOne_pkg::BLK_IDLE: begin
                    if (launch_acc && launch_blocking_i) begin
                        state_q <= maverickOne_pkg::BLK_BLOCKED;
                    end
                end
                maverickOne_pkg::BLK_BLOCKED: begin
                    if (blk_done_i) begin
                        state_q <= maverickOne_pkg::BLK_IDLE;
                    end
                end
                default: state_q <= maverickOne_pkg::BLK_IDLE;
            endcase
        end
    end

    // While a blocking instruction is pending every register, r0 included,
    // is locked.
    assign locks_o       = nonzero | {NUM_REGS{state_q == maverickOne_pkg::BLK_BLOCKED}};
    assign outstanding_o = outstanding_q;
    assign full_o        = full_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_reg_lock_tracker.sv
module tb_reg_lock_tracker;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b1;
    logic        clear_i = 1'b0;
    logic        launch_valid_i = 1'b0;
    logic [4:0]  launch_rd_i = '0;
    logic        launch_blocking_i = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic        blk_done_i = 1'b0;
    logic [31:0] locks_o;
    logic [2:0]  outstanding_o;
    logic        full_o;
    logic        err_o;

    typedef struct packed {
        logic       lv;
        logic [4:0] lrd;
        logic       lb;
        logic       wv;
        logic [4:0] wrd;
        logic       bd;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic [31:0] locks;
        logic [2:0]  outs;
        logic        full;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    reg_lock_tracker #(
        .NUM_REGS        (32),
        .NUM_OUTSTANDING (4)
    ) dut (
        .clk_i             (clk_i),
        .arst_ni           (arst_ni),
        .clear_i           (clear_i),
        .launch_valid_i    (launch_valid_i),
        .launch_rd_i       (launch_rd_i),
        .launch_blocking_i (launch_blocking_i),
        .wb_valid_i        (wb_valid_i),
        .wb_rd_i           (wb_rd_i),
        .blk_done_i        (blk_done_i),
        .locks_o           (locks_o),
        .outstanding_o     (outstanding_o),
        .full_o            (full_o),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus builders ----------------
    function automatic stim_t mk_s(input logic lv, input int lrd, input logic lb,
                                   input logic wv, input int wrd, input logic bd,
                                   input logic clr);
        stim_t s;
        s.lv  = lv;
        s.lrd = 5'(lrd);
        s.lb  = lb;
        s.wv  = wv;
        s.wrd = 5'(wrd);
        s.bd  = bd;
        s.clr = clr;
        return s;
    endfunction

    function automatic stim_t s_idle();        return mk_s(0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic stim_t s_l(input int r);  return mk_s(1, r, 0, 0, 0, 0, 0); endfunction
    function automatic stim_t s_lb(input int r); return mk_s(1, r, 1, 0, 0, 0, 0); endfunction
    function automatic stim_t s_w(input int r);  return mk_s(0, 0, 0, 1, r, 0, 0); endfunction
    function automatic stim_t s_lw(input int l, input int w); return mk_s(1, l, 0, 1, w, 0, 0); endfunction
    function automatic stim_t s_bd();          return mk_s(0, 0, 0, 0, 0, 1, 0); endfunction

    function automatic exp_t mk_e(input logic [31:0] locks, input int outs,
                                  input logic full, input logic err);
        exp_t e;
        e.locks = locks;
        e.outs  = 3'(outs);
        e.full  = full;
        e.err   = err;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.locks = locks_o;
        o.outs  = outstanding_o;
        o.full  = full_o;
        o.err   = err_o;
        return o;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("locks=%h outs=%0d full=%b err=%b", e.locks, e.outs, e.full, e.err);
    endfunction

    // Drive one cycle of stimulus, queue what the outputs must be after the
    // edge, then move to a sampling point away from the edge.
    task automatic apply(input stim_t s, input exp_t e);
        launch_valid_i    = s.lv;
        launch_rd_i       = s.lrd;
        launch_blocking_i = s.lb;
        wb_valid_i        = s.wv;
        wb_rd_i           = s.wrd;
        blk_done_i        = s.bd;
        clear_i           = s.clr;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        launch_valid_i    = 1'b0;
        launch_blocking_i = 1'b0;
        wb_valid_i        = 1'b0;
        blk_done_i        = 1'b0;
        clear_i           = 1'b0;
    endtask

    task automatic do_reset();
        arst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        arst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        exp_t got;
        #1;
        arst_ni = 1'b0;
        #11;
        got = observe();
        checks++;
        if (got !== mk_e(32'h0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_asserted: got %s want all zero", fmt(got));
        end
        arst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        got = observe();
        checks++;
        if (got !== mk_e(32'h0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_released: got %s want all zero", fmt(got));
        end
    endtask

    task automatic test_launch_wb();
        stim_t st[5];
        exp_t  ex[5];
        exp_t  got;
        exp_t  want;
        do_reset();
        st[0] = s_l(5);  ex[0] = mk_e(32'h20, 1, 0, 0);
        st[1] = s_idle(); ex[1] = mk_e(32'h20, 1, 0, 0);
        st[2] = s_w(5);  ex[2] = mk_e(32'h0, 0, 0, 0);
        st[3] = s_idle(); ex[3] = mk_e(32'h0, 0, 0, 0);
        st[4] = s_w(0);  ex[4] = mk_e(32'h0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            apply(st[i], ex[i]);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL launch_wb[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_same_cycle();
        stim_t st[7];
        exp_t  ex[7];
        exp_t  got;
        exp_t  want;
        do_reset();
        st[0] = s_l(7);      ex[0] = mk_e(32'h080, 1, 0, 0);
        st[1] = s_lw(7, 7);  ex[1] = mk_e(32'h080, 1, 0, 0);
        st[2] = s_idle();    ex[2] = mk_e(32'h080, 1, 0, 0);
        st[3] = s_w(7);      ex[3] = mk_e(32'h000, 0, 0, 0);
        st[4] = s_l(7);      ex[4] = mk_e(32'h080, 1, 0, 0);
        st[5] = s_lw(8, 7);  ex[5] = mk_e(32'h100, 1, 0, 0);
        st[6] = s_w(8);      ex[6] = mk_e(32'h000, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            apply(st[i], ex[i]);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL same_cycle[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_blocking();
        stim_t st[4];
        exp_t  ex[4];
        exp_t  got;
        exp_t  want;
        do_reset();
        st[0] = s_lb(3); ex[0] = mk_e(32'hFFFF_FFFF, 1, 0, 0);
        st[1] = s_l(4);  ex[1] = mk_e(32'hFFFF_FFFF, 1, 0, 1);
        st[2] = s_bd();  ex[2] = mk_e(32'h0000_0008, 1, 0, 1);
        st[3] = s_w(3);  ex[3] = mk_e(32'h0000_0000, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ex[i]);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL blocking[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_blk_done_idle();
        exp_t got;
        exp_t want;
        do_reset();
        apply(s_bd(), mk_e(32'h0, 0, 0, 1));
        got  = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL blk_done_idle: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_full();
        stim_t st[8];
        exp_t  ex[8];
        exp_t  got;
        exp_t  want;
        do_reset();
        st[0] = s_l(1);     ex[0] = mk_e(32'h02, 1, 0, 0);
        st[1] = s_l(2);     ex[1] = mk_e(32'h06, 2, 0, 0);
        st[2] = s_l(3);     ex[2] = mk_e(32'h0E, 3, 0, 0);
        st[3] = s_l(4);     ex[3] = mk_e(32'h1E, 4, 1, 0);
        st[4] = s_l(5);     ex[4] = mk_e(32'h1E, 4, 1, 1);
        st[5] = s_lw(5, 1); ex[5] = mk_e(32'h3C, 4, 1, 1);
        st[6] = mk_s(1, 6, 0, 1, 2, 0, 1); ex[6] = mk_e(32'h00, 0, 0, 1);
        st[7] = s_idle();   ex[7] = mk_e(32'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            apply(st[i], ex[i]);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL full[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_errors();
        stim_t st[4];
        exp_t  ex[4];
        exp_t  got;
        exp_t  want;
        do_reset();
        st[0] = s_l(5); ex[0] = mk_e(32'h20, 1, 0, 0);
        st[1] = s_w(9); ex[1] = mk_e(32'h20, 1, 0, 1);
        st[2] = s_l(0); ex[2] = mk_e(32'h20, 2, 0, 1);
        st[3] = s_w(5); ex[3] = mk_e(32'h00, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ex[i]);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL errors[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  got;
        exp_t  want;
        do_reset();
        st[0] = s_l(10);  ex[0] = mk_e(32'h0000_0400, 1, 0, 0);
        st[1] = s_lb(11); ex[1] = mk_e(32'hFFFF_FFFF, 2, 0, 0);
        st[2] = s_l(12);  ex[2] = mk_e(32'hFFFF_FFFF, 2, 0, 1);
        for (int i = 0; i < 3; i++) begin
            apply(st[i], ex[i]);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_pre[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
        arst_ni = 1'b0;
        #2;
        got = observe();
        checks++;
        if (got !== mk_e(32'h0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_mid_async: got %s want all zero", fmt(got));
        end
        arst_ni = 1'b1;
        apply(s_idle(), mk_e(32'h0, 0, 0, 0));
        got  = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_mid_after: got %s want %s", fmt(got), fmt(want));
        end
        apply(s_l(12), mk_e(32'h0000_1000, 1, 0, 0));
        got  = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_mid_relaunch: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    initial begin
        test_reset();
        test_launch_wb();
        test_same_cycle();
        test_blocking();
        test_blk_done_idle();
        test_full();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_lock_tracker.md
REG_LOCK_TRACKER -- requirements
Module: reg_lock_tracker

Interface
REQ-001 Parameter NUM_REGS, default maverickOne_pkg::NUM_REGS (32), number of architectural registers.
REQ-002 Parameter NUM_OUTSTANDING, default maverickOne_pkg::NUM_OUTSTANDING, maximum in-flight launched instructions.
REQ-003 clk_i  in  1  single system clock; all state updates on rising edge.
REQ-004 arst_ni  in  1  asynchronous active-low reset.
REQ-005 clear_i  in  1  synchronous flush; highest priority after reset.
REQ-006 launch_valid_i  in  1  launcher output fire (instr_out_valid & instr_out_ready) this cycle.
REQ-007 launch_rd_i  in  log2(NUM_REGS)  destination register of the launched instruction.
REQ-008 launch_blocking_i  in  1  launched instruction is blocking.
REQ-009 wb_valid_i  in  1  one write-back completion this cycle.
REQ-010 wb_rd_i  in  log2(NUM_REGS)  register completed by write-back.
REQ-011 blk_done_i  in  1  the pending blocking instruction has retired.
REQ-012 locks_o  out  NUM_REGS  per-register lock vector, fed to launcher locks_i.
REQ-013 outstanding_o  out  log2(NUM_OUTSTANDING+1)  in-flight instruction count.
REQ-014 full_o  out  1  outstanding_o == NUM_OUTSTANDING.
REQ-015 err_o  out  1  sticky protocol-error flag.

Function
REQ-016 Per-register counter cnt[r], width log2(NUM_OUTSTANDING+1); launch to r increments, write-back to r decrements.
REQ-017 Launch and write-back to the same r in one cycle: cnt[r] unchanged; to different registers: both applied.
REQ-018 Register 0: launches and write-backs to rd=0 do not modify cnt[0]; cnt[0] stays 0.
REQ-019 Global counter outstanding_o: +1 on accepted launch, -1 on accepted write-back, unchanged when both occur.
REQ-020 Launch while full_o=1 (without same-cycle write-back): ignored, err_o set.
REQ-021 Write-back to r with cnt[r]=0: ignored, err_o set.
REQ-022 Blocking FSM: IDLE -> BLOCKED on accepted launch with launch_blocking_i=1; BLOCKED -> IDLE on blk_done_i=1.
REQ-023 Blocking launch also increments cnt[rd] as a normal launch.
REQ-024 Launch while BLOCKED: ignored, err_o set. blk_done_i while IDLE: ignored, err_o set.
REQ-025 locks_o[r] = (cnt[r] != 0) or (state == BLOCKED) for r>0; locks_o[0] = BLOCKED.
REQ-026 locks_o, full_o, outstanding_o are registered; new values visible the cycle after the triggering edge (latency 1).
REQ-027 clear_i=1: all counters 0, state IDLE, err_o unchanged; same-cycle launch/write-back discarded.
REQ-028 err_o clears only on reset.

Reset
REQ-029 arst_ni low asynchronously forces all cnt 0, outstanding_o 0, state IDLE, locks_o 0, full_o 0, err_o 0.
REQ-030 Reset asserted mid-operation discards all in-flight tracking; no residual locks after release.

Structure
REQ-031 NUM_REGS, NUM_OUTSTANDING and the blocking state enum belong in maverickOne_pkg.
REQ-032 One sub-module reg_lock_cnt (single saturating up/down counter with inc, dec, clear, nonzero output), instantiated NUM_REGS-1 times.

Verification
REQ-033 Reset: after arst_ni release, locks_o=0, outstanding_o=0, full_o=0, err_o=0.
REQ-034 Launch rd=5, then write-back rd=5 two cycles later -> locks_o[5]=1 for exactly two cycles, outstanding_o 1 then 0.
REQ-035 Same-cycle launch rd=7 and write-back rd=7 with cnt[7]=1 -> locks_o[7] stays 1, outstanding_o unchanged.
REQ-036 Blocking launch rd=3 -> locks_o=all ones next cycle; launch attempt sets err_o; blk_done_i then write-back rd=3 -> locks_o=0.
REQ-037 NUM_OUTSTANDING launches to rd=1..N -> full_o=1; extra launch -> err_o=1, outstanding_o stays N; clear_i -> locks_o=0, full_o=0.
REQ-038 Write-back rd=9 with cnt[9]=0 -> err_o=1, locks_o and outstanding_o unchanged; launch rd=0 -> locks_o[0]=0.
